// File: rtl/jtbubl_rom_arb.sv
// Shares one graphics SDRAM ROM slot between two fetch ports (A: object/tile, B: second engine).
// Each port keeps a one-entry result cache so repeated reads of one address skip the SDRAM.
module jtbubl_rom_arb #(
  parameter int AW = 18,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inv,
  input  logic          a_cs,
  input  logic [AW-1:0] a_addr,
  output logic [DW-1:0] a_data,
  output logic          a_ok,
  input  logic          b_cs,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_data,
  output logic          b_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  typedef enum logic [1:0] {IDLE, SKIP, WAIT} state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t        state_q;
  logic          gnt_q;
  logic          last_q;
  logic          gap_q;
  logic          rom_cs_q;
  logic [AW-1:0] rom_addr_q;
  logic          vld_a_q, vld_b_q;
  logic [AW-1:0] cadr_a_q, cadr_b_q;
  logic [DW-1:0] cdat_a_q, cdat_b_q;

  logic          hit_a, hit_b;
  logic          pend_a, pend_b;
  logic          grant_b;
  logic          g_cs;
  logic [AW-1:0] g_addr;
  logic          abort;

  assign hit_a  = vld_a_q && (a_addr == cadr_a_q);
  assign hit_b  = vld_b_q && (b_addr == cadr_b_q);
  assign pend_a = a_cs && !hit_a;
  assign pend_b = b_cs && !hit_b;

  assign a_ok   = a_cs && hit_a;
  assign b_ok   = b_cs && hit_b;
  assign a_data = cdat_a_q;
  assign b_data = cdat_b_q;

  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;

  // B wins only when A is idle or A was the last port served
  assign grant_b = pend_b && (!pend_a || (last_q == PORT_A));

  assign g_cs   = (gnt_q == PORT_B) ? b_cs   : a_cs;
  assign g_addr = (gnt_q == PORT_B) ? b_addr : a_addr;
  assign abort  = !g_cs || (g_addr != rom_addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= PORT_A;
      last_q     <= PORT_B;
      gap_q      <= 1'b0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      vld_a_q    <= 1'b0;
      vld_b_q    <= 1'b0;
      cadr_a_q   <= '0;
      cadr_b_q   <= '0;
      cdat_a_q   <= '0;
      cdat_b_q   <= '0;
    end else begin
      gap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // gap_q keeps rom_cs low for a whole IDLE cycle before the next grant
          if (!gap_q && (pend_a || pend_b)) begin
            gnt_q      <= grant_b ? PORT_B : PORT_A;
            rom_addr_q <= grant_b ? b_addr : a_addr;
            rom_cs_q   <= 1'b1;
            state_q    <= SKIP;
          end
        end
        SKIP: begin
          if (abort) begin
            rom_cs_q <= 1'b0;
            gap_q    <= 1'b1;
            state_q  <= IDLE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            rom_cs_q <= 1'b0;
            gap_q    <= 1'b1;
            state_q  <= IDLE;
          end else if (rom_ok) begin
            if (gnt_q == PORT_B) begin
              cdat_b_q <= rom_data;
              cadr_b_q <= rom_addr_q;
              vld_b_q  <= 1'b1;
            end else begin
              cdat_a_q <= rom_data;
              cadr_a_q <= rom_addr_q;
              vld_a_q  <= 1'b1;
            end
            rom_cs_q <= 1'b0;
            last_q   <= gnt_q;
            gap_q    <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          rom_cs_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
      // placed last so an invalidate overrides a fill in the same cycle
      if (inv) begin
        vld_a_q <= 1'b0;
        vld_b_q <= 1'b0;
      end
    end
  end

endmodule
